// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the master FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } mst_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command stream into
// AXI4-Lite write/read transactions and returns each result on a response stream.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int ERR_CNT_WIDTH      = 8
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0]          err_count,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

    mst_state_t r_state;
    logic       r_write;
    logic       r_aw_done;
    logic       r_w_done;

    logic       w_aw_fire;
    logic       w_w_fire;
    logic       w_aw_ok;
    logic       w_w_ok;
    logic       w_cap_en;
    logic [1:0] w_cap_resp;

    assign cmd_ready    = (r_state == IDLE);
    assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
    assign M_AXI_ARPROT = AXI_PROT_DEFAULT;

    // AW and W complete independently; either may land first or both together.
    assign w_aw_fire = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_fire  = M_AXI_WVALID & M_AXI_WREADY;
    assign w_aw_ok   = r_aw_done | w_aw_fire;
    assign w_w_ok    = r_w_done | w_w_fire;

    assign w_cap_en   = ((r_state == WR_RESP) & M_AXI_BVALID) |
                        ((r_state == RD_RESP) & M_AXI_RVALID);
    assign w_cap_resp = (r_state == WR_RESP) ? M_AXI_BRESP : M_AXI_RRESP;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state       <= IDLE;
            r_write       <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_RESP_OKAY;
            err_count     <= '0;
        end else begin
            if (w_cap_en && (w_cap_resp != AXI_RESP_OKAY) && (err_count != '1))
                err_count <= err_count + ERR_ONE;

            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_write <= cmd_write;
                        if (cmd_write) begin
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            r_aw_done     <= 1'b0;
                            r_w_done      <= 1'b0;
                            r_state       <= WR_REQ;
                        end else begin
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                            r_state       <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (w_aw_fire) begin
                        M_AXI_AWVALID <= 1'b0;
                        r_aw_done     <= 1'b1;
                    end
                    if (w_w_fire) begin
                        M_AXI_WVALID <= 1'b0;
                        r_w_done     <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        M_AXI_BREADY <= 1'b1;
                        r_state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_write    <= r_write;
                        rsp_valid    <= 1'b1;
                        r_state      <= RSP;
                    end
                end
                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        r_state       <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_write    <= r_write;
                        rsp_valid    <= 1'b1;
                        r_state      <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite master that converts a simple valid/ready command stream (from a test sequencer or soft-CPU shim) into AXI4-Lite write and read transactions toward `axi_peripheral_top`. It returns each transaction's result on a valid/ready response stream and keeps a saturating count of error responses. It is the stage directly upstream of the peripheral's `S_AXI_*` port.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, address width; matches the peripheral's `C_S_AXI_ADDR_WIDTH`.
- `C_M_AXI_DATA_WIDTH`, 32, data width; only 32 is supported.
- `ERR_CNT_WIDTH`, 8, width of the saturating error counter.

Ports (clock and reset first):
- `M_AXI_ACLK` in 1: single clock for all logic.
- `M_AXI_ARESET` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR: transaction address.
- `cmd_wdata` in DATA: write data.
- `cmd_wstrb` in DATA/8: write strobes; ignored for reads.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_write` out 1: echoes `cmd_write` of the completed transaction.
- `rsp_rdata` out DATA: RDATA for reads; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP.
- `err_count` out ERR_CNT_WIDTH: number of non-OKAY responses, saturating.
- `M_AXI_AWADDR`, `M_AXI_AWPROT` (3), `M_AXI_AWVALID` out; `M_AXI_AWREADY` in.
- `M_AXI_WDATA`, `M_AXI_WSTRB`, `M_AXI_WVALID` out; `M_AXI_WREADY` in.
- `M_AXI_BRESP` (2), `M_AXI_BVALID` in; `M_AXI_BREADY` out.
- `M_AXI_ARADDR`, `M_AXI_ARPROT` (3), `M_AXI_ARVALID` out; `M_AXI_ARREADY` in.
- `M_AXI_RDATA`, `M_AXI_RRESP` (2), `M_AXI_RVALID` in; `M_AXI_RREADY` out.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- **IDLE**
  - `cmd_ready` = 1 only in IDLE.
  - On a handshake, register addr, wdata, wstrb and write.
  - Go to WR_REQ if write, else RD_REQ.
- **WR_REQ**
  - AWVALID and WVALID are asserted together on entry.
  - Each VALID drops independently on its own handshake (VALID & READY).
  - Leave to WR_RESP once both handshakes have completed, in either order or the same cycle.
  - Use `aw_done`/`w_done` flags to track completion.
- **WR_RESP**: BREADY = 1. On BVALID, capture BRESP, set `rsp_rdata` = 0, go to RSP.
- **RD_REQ**: ARVALID = 1 until ARREADY, then go to RD_RESP.
- **RD_RESP**: RREADY = 1. On RVALID, capture RDATA and RRESP, go to RSP.
- **RSP**: `rsp_valid` = 1. Hold `rsp_*` stable until `rsp_ready`, then go to IDLE.
- AWPROT = ARPROT = 3'b000, constant.
- AW/W/AR payloads are held stable while their VALID is high (AXI rule: VALID is never withdrawn before its READY).
- `err_count` increments on each captured response ≠ 2'b00 and saturates at all-ones.
- No timeout: a slave that never responds stalls the block until reset.
- Reset, including mid-transaction, asynchronously forces:
  - state IDLE;
  - all VALID/READY outputs 0;
  - `rsp_*` 0 and `err_count` 0;
  - address and data outputs 0.

## Timing
- All outputs are registered, except `cmd_ready`, which is decoded from state.
- Cycle 0: command accepted. Cycle 1: AW/W (or AR) VALID high.
- With a zero-wait slave (READY already high, response the cycle after the address):
  - cycle 1: address/data handshake;
  - cycle 2: B/R handshake;
  - cycle 3: `rsp_valid` = 1.
- Minimum command-to-response latency is therefore 3 cycles.
- If `rsp_ready` is already high in cycle 3, IDLE is reached in cycle 4, so throughput is at most one transaction per 4 cycles.
- BREADY/RREADY are high for the whole of WR_RESP/RD_RESP, so a BVALID/RVALID arriving in the first cycle is accepted in that cycle.
- No new command is accepted while `rsp_valid` is high (single outstanding transaction).

## Structure
- Shared package `axi_lite_pkg`:
  - response constants `AXI_RESP_OKAY` = 2'b00, `AXI_RESP_EXOKAY` = 2'b01, `AXI_RESP_SLVERR` = 2'b10, `AXI_RESP_DECERR` = 2'b11;
  - `AXI_PROT_DEFAULT` = 3'b000;
  - FSM state encoding `mst_state_t`.
- One flat module with no sub-modules. The saturating counter is about 5 lines inline.

## Test plan
- **Write, zero-wait slave.** Write addr 0x0000_0000, data 0x0000_00A5, strb 0xF, slave READY held high. Expect:
  - AWVALID/WVALID high in cycle 1 only;
  - `rsp_valid` in cycle 3 with `rsp_write` = 1, `rsp_resp` = 0, `rsp_rdata` = 0.
- **Read.** Read addr 0x0000_0004, slave returns RDATA 0x0000_1234 with OKAY. Expect `rsp_rdata` = 0x0000_1234, `rsp_write` = 0, ARVALID high for exactly 1 cycle.
- **Skewed write handshakes.** WREADY high at cycle 1, AWREADY delayed until cycle 4. Expect:
  - WVALID drops at cycle 2;
  - AWVALID stays high with stable AWADDR through cycle 4;
  - BREADY rises at cycle 5.
- **Error responses.** Slave returns SLVERR on 3 transactions. Expect `err_count` = 3. Preload by running 260 DECERR transactions: expect `err_count` = 255 (saturated).
- **Response backpressure.** Hold `rsp_ready` low for 5 cycles after `rsp_valid`. Expect `rsp_*` stable, `cmd_ready` = 0, no AXI VALID asserted; IDLE is reached the cycle after `rsp_ready` rises.
- **Reset mid-transaction.** Assert `M_AXI_ARESET` while AWVALID is high waiting for AWREADY. Expect AWVALID, WVALID and `rsp_valid` = 0 within the same cycle (asynchronous), and `cmd_ready` = 1 after release.
